// File: rtl/serial_frame_sender_if.sv
// Word-entry handshake for serial_frame_sender.
// The producer drives data_in/data_valid; the sender answers with data_ready.
interface serial_frame_sender_if #(
  parameter int WORD_SIZE = 27
);
  logic [WORD_SIZE-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/serial_frame_sender.sv
// UART-style frame transmitter fed by a small word FIFO.
// Each queued word leaves as: start bit, WORD_SIZE data bits (MSB or LSB first),
// optional even/odd parity bit, then one or two stop bits. Every bit is held
// for CLKS_PER_BIT clocks. Frames run back to back while the FIFO has data.
module serial_frame_sender #(
  parameter int WORD_SIZE    = 27,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  serial_frame_sender_if.slave     bus,
  output logic                     serialOut,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  // Value of the stop counter during the final stop bit.
  localparam logic             STOP_LAST  = (STOP_BITS == 2);
  localparam logic             HAS_PARITY = (PARITY != 0);
  localparam logic             ODD_PARITY = (PARITY == 2);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 ready;
  logic [WORD_SIZE-1:0] head_word;
  logic                 head_parity;

  // Readiness looks only at the stored count, so a full FIFO refuses a push
  // even when a word is leaving on the same edge.
  assign ready          = (count_q < FULL_COUNT);
  assign bus.data_ready = ready;
  assign push           = bus.data_valid && ready;
  assign head_word      = mem_q[rd_ptr_q];
  // Parity is taken from the whole word at pop time, before any shifting.
  assign head_parity    = (^head_word) ^ ODD_PARITY;

  // Pointer and occupancy update; power-of-two depth lets pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Word storage write; no reset because unused slots are don't-care.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // FIFO pointer and count registers; reset flushes the queue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit shift register and bit ordering
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] shift_adv;
  logic                 cur_bit;
  logic                 adv_bit;

  // The outgoing bit is always at one end of the register; shifting moves
  // the next bit into that position.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_adv = shift_q << 1;
      assign cur_bit   = shift_q[WORD_SIZE-1];
      assign adv_bit   = shift_adv[WORD_SIZE-1];
    end else begin : g_lsb_first
      assign shift_adv = shift_q >> 1;
      assign cur_bit   = shift_q[0];
      assign adv_bit   = shift_adv[0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             parity_q, parity_d;
  logic             stop_q, stop_d;
  logic             line_q, line_d;
  logic             busy_q, busy_d;
  logic             wrap;
  logic             start_frame;

  // The bit or state only advances when the baud divider wraps.
  assign wrap = (div_q == DIV_LAST);

  // Next-state logic: the line and busy registers are loaded with the value
  // belonging to the state being entered, so both are glitch-free outputs.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    stop_d      = stop_q;
    line_d      = line_q;
    busy_d      = busy_q;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        if (count_q != '0) begin
          start_frame = 1'b1;
        end
      end

      ST_START: begin
        if (wrap) begin
          div_d   = '0;
          state_d = ST_DATA;
          bit_d   = BIT_TOP;
          line_d  = cur_bit;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_DATA: begin
        if (wrap) begin
          div_d = '0;
          if (bit_q == '0) begin
            if (HAS_PARITY) begin
              state_d = ST_PAR;
              line_d  = parity_q;
            end else begin
              state_d = ST_STOP;
              line_d  = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q - BIT_ONE;
            shift_d = shift_adv;
            line_d  = adv_bit;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_PAR: begin
        if (wrap) begin
          div_d   = '0;
          state_d = ST_STOP;
          line_d  = 1'b1;
          stop_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_STOP: begin
        if (wrap) begin
          div_d = '0;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next frame when a word is waiting.
            if (count_q != '0) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              line_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (start_frame) begin
      state_d  = ST_START;
      div_d    = '0;
      shift_d  = head_word;
      parity_d = head_parity;
      line_d   = 1'b0;
      busy_d   = 1'b1;
    end
  end

  assign pop = start_frame;

  // Sequencer registers; reset abandons any frame and parks the line high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
    end
  end

  assign serialOut  = line_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Randomized bench for serial_frame_sender. Three differently configured
// instances share clock and reset. A reference model keeps each instance's
// word queue and the list of line levels still owed, one entry per clock.
module tb_serial_frame_sender;

  localparam int N     = 3;
  localparam int TOTAL = 3000;
  localparam int DRAIN = 400;

  // Per-instance configuration: A, B, C (C uses all defaults).
  localparam int CFG_W     [N] = '{8, 5, 27};
  localparam int CFG_DEPTH [N] = '{4, 2, 4};
  localparam int CFG_CPB   [N] = '{3, 2, 1};
  localparam int CFG_MSB   [N] = '{0, 1, 1};
  localparam int CFG_PAR   [N] = '{1, 2, 0};
  localparam int CFG_STOP  [N] = '{2, 1, 1};

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic [63:0] drv_data  [N];
  logic        drv_valid [N];

  serial_frame_sender_if #(.WORD_SIZE(8))  bus_a ();
  serial_frame_sender_if #(.WORD_SIZE(5))  bus_b ();
  serial_frame_sender_if #(.WORD_SIZE(27)) bus_c ();

  assign bus_a.data_in    = drv_data[0][7:0];
  assign bus_a.data_valid = drv_valid[0];
  assign bus_b.data_in    = drv_data[1][4:0];
  assign bus_b.data_valid = drv_valid[1];
  assign bus_c.data_in    = drv_data[2][26:0];
  assign bus_c.data_valid = drv_valid[2];

  logic       so_a, busy_a, so_b, busy_b, so_c, busy_c;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;

  serial_frame_sender #(
    .WORD_SIZE(8), .DEPTH(4), .CLKS_PER_BIT(3),
    .MSB_FIRST(0), .PARITY(1), .STOP_BITS(2)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave),
    .serialOut(so_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  serial_frame_sender #(
    .WORD_SIZE(5), .DEPTH(2), .CLKS_PER_BIT(2),
    .MSB_FIRST(1), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave),
    .serialOut(so_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  serial_frame_sender dut_c (
    .clock(clock), .reset_n(reset_n), .bus(bus_c.slave),
    .serialOut(so_c), .busy(busy_c), .fifo_count(cnt_c)
  );

  // Reference model state.
  logic [63:0] mq [N][$];
  logic        lq [N][$];
  logic        exp_so   [N];
  logic        exp_busy [N];
  int          exp_cnt  [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input int i, output logic so, output logic bz,
                        output logic [63:0] cnt, output logic rdy);
    case (i)
      0: begin so = so_a; bz = busy_a; cnt = 64'(cnt_a); rdy = bus_a.data_ready; end
      1: begin so = so_b; bz = busy_b; cnt = 64'(cnt_b); rdy = bus_b.data_ready; end
      default: begin so = so_c; bz = busy_c; cnt = 64'(cnt_c); rdy = bus_c.data_ready; end
    endcase
  endtask

  // Owed line levels for one whole frame of word w.
  task automatic append_frame(input int i, input logic [63:0] w);
    logic b;
    logic p;
    int   cpb;
    cpb = CFG_CPB[i];
    repeat (cpb) lq[i].push_back(1'b0);
    p = 1'b0;
    for (int k = 0; k < CFG_W[i]; k++) begin
      b = (CFG_MSB[i] != 0) ? w[CFG_W[i]-1-k] : w[k];
      p = p ^ w[k];
      repeat (cpb) lq[i].push_back(b);
    end
    if (CFG_PAR[i] != 0) begin
      if (CFG_PAR[i] == 2) p = ~p;
      repeat (cpb) lq[i].push_back(p);
    end
    repeat (CFG_STOP[i] * cpb) lq[i].push_back(1'b1);
  endtask

  // What one rising edge does, given the inputs presented before it.
  task automatic model_edge(input int i, input logic valid, input logic [63:0] data);
    logic        accept;
    logic [63:0] w;
    accept = valid && (mq[i].size() < CFG_DEPTH[i]);
    if (lq[i].size() == 0 && mq[i].size() > 0) begin
      w = mq[i].pop_front();
      append_frame(i, w);
    end
    if (accept) begin
      mq[i].push_back(data);
      $display("push dut=%0d word=%0h queued=%0d t=%0t", i, data, mq[i].size(), $time);
    end
    if (lq[i].size() > 0) begin
      exp_so[i]   = lq[i].pop_front();
      exp_busy[i] = 1'b1;
    end else begin
      exp_so[i]   = 1'b1;
      exp_busy[i] = 1'b0;
    end
    exp_cnt[i] = mq[i].size();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      lq[i].delete();
      exp_so[i]   = 1'b1;
      exp_busy[i] = 1'b0;
      exp_cnt[i]  = 0;
    end
  endtask

  task automatic check_all(input string when);
    logic        so, bz, rdy;
    logic [63:0] cnt;
    for (int i = 0; i < N; i++) begin
      sample(i, so, bz, cnt, rdy);
      check_eq($sformatf("%s.line%0d", when, i), 64'(so), 64'(exp_so[i]));
      check_eq($sformatf("%s.busy%0d", when, i), 64'(bz), 64'(exp_busy[i]));
      check_eq($sformatf("%s.count%0d", when, i), cnt, 64'(exp_cnt[i]));
      check_eq($sformatf("%s.ready%0d", when, i), 64'(rdy),
               64'(exp_cnt[i] < CFG_DEPTH[i]));
    end
  endtask

  initial begin
    logic        rst_done;
    int          pct;
    int          frame_len;
    int          tail_len;
    logic [63:0] mask;

    rst_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
    end
    model_reset();
    #1 reset_n = 1'b0;

    for (int cyc = 0; cyc < TOTAL + DRAIN; cyc++) begin
      @(negedge clock);
      check_all("cyc");

      if (reset_n == 1'b0) begin
        reset_n = 1'b1;
      end else if (!rst_done && cyc >= 1000) begin
        frame_len = (1 + CFG_W[0] + ((CFG_PAR[0] != 0) ? 1 : 0) + CFG_STOP[0]) * CFG_CPB[0];
        tail_len  = (((CFG_PAR[0] != 0) ? 1 : 0) + CFG_STOP[0]) * CFG_CPB[0];
        if ((mq[0].size() >= 2 && lq[0].size() >= tail_len &&
             lq[0].size() < frame_len - CFG_CPB[0] - 1) || cyc >= 1600) begin
          // Asynchronous reset in mid-frame: outputs must clear with no edge.
          rst_done = 1'b1;
          for (int i = 0; i < N; i++) drv_valid[i] = 1'b0;
          $display("reset mid-frame cyc=%0d queued_a=%0d t=%0t", cyc, mq[0].size(), $time);
          reset_n = 1'b0;
          model_reset();
          #1;
          check_all("rst");
          continue;
        end
      end

      // Phases: heavy traffic (backpressure), moderate, sparse; then drain.
      case ((cyc / 250) % 3)
        0:       pct = 90;
        1:       pct = 30;
        default: pct = 5;
      endcase
      if (cyc >= TOTAL) pct = 0;

      for (int i = 0; i < N; i++) begin
        mask = (64'd1 << CFG_W[i]) - 64'd1;
        drv_valid[i] = ($urandom_range(99) < pct);
        drv_data[i]  = {32'($urandom), 32'($urandom)} & mask;
        if (cyc == 0) begin
          drv_valid[i] = 1'b1;
          case (i)
            0:       drv_data[i] = 64'h07;
            1:       drv_data[i] = 64'h15;
            default: drv_data[i] = 64'h4000001;
          endcase
        end
        model_edge(i, drv_valid[i], drv_data[i]);
      end
    end

    @(negedge clock);
    check_all("end");
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("drained%0d", i), 64'(lq[i].size() + mq[i].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
